// File: rtl/demux16_stream.sv
// 1-to-2 buffered stream demux: each word goes to one of two FIFOs chosen by in_select; 1-cycle latency.
// in_ready drops when the selected FIFO is full. Define DEMUX_COUNT_EN to add the per-output pop counters.

module demux16_stream_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 2,
  parameter int AW    = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_valid,
  input  logic [WIDTH-1:0] wr_data,
  output logic             wr_ready,
  output logic             rd_valid,
  output logic [WIDTH-1:0] rd_data,
  input  logic             rd_ready
);
  localparam logic [AW:0] FULL_OCC = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      occ;
  logic             push;
  logic             pop;

  // Full is judged on current occupancy only, so a popping full FIFO still refuses.
  assign wr_ready = (occ != FULL_OCC);
  assign rd_valid = (occ != '0);
  assign rd_data  = mem[rd_ptr];
  assign push     = wr_valid && wr_ready;
  assign pop      = rd_valid && rd_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (push) begin
        mem[wr_ptr] <= wr_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   occ <= occ + 1'b1;
        2'b01:   occ <= occ - 1'b1;
        default: occ <= occ;
      endcase
    end
  end
endmodule

module demux16_stream #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 2,
  parameter int AW    = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_select,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out0_data,
  output logic             out0_valid,
  input  logic             out0_ready,
  output logic [WIDTH-1:0] out1_data,
  output logic             out1_valid,
  input  logic             out1_ready
`ifdef DEMUX_COUNT_EN
  ,
  output logic [15:0]      out0_count,
  output logic [15:0]      out1_count
`endif
);
  logic wr_ready0;
  logic wr_ready1;

  assign in_ready = in_select ? wr_ready1 : wr_ready0;

  demux16_stream_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) u_fifo0 (
    .clk      (clk),
    .rst      (rst),
    .wr_valid (in_valid && !in_select),
    .wr_data  (in_data),
    .wr_ready (wr_ready0),
    .rd_valid (out0_valid),
    .rd_data  (out0_data),
    .rd_ready (out0_ready)
  );

  demux16_stream_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) u_fifo1 (
    .clk      (clk),
    .rst      (rst),
    .wr_valid (in_valid && in_select),
    .wr_data  (in_data),
    .wr_ready (wr_ready1),
    .rd_valid (out1_valid),
    .rd_data  (out1_data),
    .rd_ready (out1_ready)
  );

`ifdef DEMUX_COUNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out0_count <= '0;
      out1_count <= '0;
    end else begin
      if (out0_valid && out0_ready) out0_count <= out0_count + 16'd1;
      if (out1_valid && out1_ready) out1_count <= out1_count + 16'd1;
    end
  end
`endif
endmodule

// File: tb/tb_demux16_stream.sv
// Scoreboard bench for demux16_stream; the counter section runs only with DEMUX_COUNT_EN.
module tb_demux16_stream;
  logic        clk;
  logic        rst;
  logic [15:0] in_data;
  logic        in_select;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] out0_data;
  logic        out0_valid;
  logic        out0_ready;
  logic [15:0] out1_data;
  logic        out1_valid;
  logic        out1_ready;
`ifdef DEMUX_COUNT_EN
  logic [15:0] out0_count;
  logic [15:0] out1_count;
`endif

  int checks   = 0;
  int failures = 0;
  logic [15:0] q0[$];
  logic [15:0] q1[$];

  demux16_stream dut (
    .clk        (clk),
    .rst        (rst),
    .in_data    (in_data),
    .in_select  (in_select),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out0_data  (out0_data),
    .out0_valid (out0_valid),
    .out0_ready (out0_ready),
    .out1_data  (out1_data),
    .out1_valid (out1_valid),
    .out1_ready (out1_ready)
`ifdef DEMUX_COUNT_EN
    ,
    .out0_count (out0_count),
    .out1_count (out1_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Monitor: the handshake seen at negedge is the one the next posedge commits.
  always @(negedge clk) begin
    if (!rst) begin
      if (out0_valid && out0_ready) begin
        if (q0.size() == 0) chk("out0_unexpected_word", out0_data, 16'hxxxx);
        else chk("out0_data", out0_data, q0.pop_front());
      end
      if (out1_valid && out1_ready) begin
        if (q1.size() == 0) chk("out1_unexpected_word", out1_data, 16'hxxxx);
        else chk("out1_data", out1_data, q1.pop_front());
      end
    end
  end

  task automatic push(input logic [15:0] d, input logic s);
    bit done = 0;
    in_data   = d;
    in_select = s;
    in_valid  = 1'b1;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      if (in_ready) begin
        if (s) q1.push_back(d);
        else   q0.push_back(d);
        done = 1;
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    if (!done) chk("push_timeout", 16'd0, 16'd1);
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    rst = 1'b1; in_data = 16'h1234; in_select = 1'b0; in_valid = 1'b1;
    out0_ready = 1'b1; out1_ready = 1'b1;

    // 1: reset state with in_valid asserted
    #1;
    chk("rst_in_ready", {15'd0, in_ready}, 16'd1);
    chk("rst_out0_valid", {15'd0, out0_valid}, 16'd0);
    chk("rst_out1_valid", {15'd0, out1_valid}, 16'd0);
    chk("rst_out0_data", out0_data, 16'h0000);
    chk("rst_out1_data", out1_data, 16'h0000);
    cycles(2);
    chk("rst_hold_out0_valid", {15'd0, out0_valid}, 16'd0);
    in_valid = 1'b0;
    rst = 1'b0;
    cycles(1);

    // 2: routing and one-cycle latency
    push(16'h00AA, 1'b0);
    chk("route_out0_valid", {15'd0, out0_valid}, 16'd1);
    chk("route_out0_data", out0_data, 16'h00AA);
    chk("route_out1_idle", {15'd0, out1_valid}, 16'd0);
    push(16'h0055, 1'b1);
    chk("route_out1_valid", {15'd0, out1_valid}, 16'd1);
    chk("route_out1_data", out1_data, 16'h0055);
    chk("route_out0_drained", {15'd0, out0_valid}, 16'd0);
    cycles(2);

    // 3: backpressure on out0, full FIFO blocks only its own select
    out0_ready = 1'b0;
    push(16'h1111, 1'b0);
    push(16'h2222, 1'b0);
    in_valid = 1'b1; in_select = 1'b0; in_data = 16'h3333;
    #1;
    chk("full_sel0_in_ready", {15'd0, in_ready}, 16'd0);
    in_select = 1'b1;
    #1;
    chk("full_sel1_in_ready", {15'd0, in_ready}, 16'd1);
    in_valid = 1'b0;
    cycles(2);
    chk("hold_out0_data", out0_data, 16'h1111);
    in_valid = 1'b1; in_select = 1'b0; out0_ready = 1'b1;
    #1;
    chk("full_popping_in_ready", {15'd0, in_ready}, 16'd0);
    in_valid = 1'b0;
    cycles(3);
    chk("bp_drained", {15'd0, out0_valid}, 16'd0);

    // 4: simultaneous push and pop at occupancy 1
    out0_ready = 1'b0;
    push(16'hA0A0, 1'b0);
    out0_ready = 1'b1;
    push(16'hB0B0, 1'b0);
    out0_ready = 1'b0;
    chk("simul_head", out0_data, 16'hB0B0);
    chk("simul_valid", {15'd0, out0_valid}, 16'd1);
    push(16'hC0C0, 1'b0);
    in_select = 1'b0;
    #1;
    chk("simul_now_full", {15'd0, in_ready}, 16'd0);
    out0_ready = 1'b1;
    cycles(3);

    // 5: asynchronous reset with both FIFOs full
    out0_ready = 1'b0; out1_ready = 1'b0;
    push(16'hD000, 1'b0);
    push(16'hD001, 1'b0);
    push(16'hD100, 1'b1);
    push(16'hD101, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_out0_valid", {15'd0, out0_valid}, 16'd0);
    chk("mid_rst_out1_valid", {15'd0, out1_valid}, 16'd0);
    chk("mid_rst_in_ready", {15'd0, in_ready}, 16'd1);
    q0.delete();
    q1.delete();
    #3;
    rst = 1'b0;
    out0_ready = 1'b1; out1_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("post_rst_out0_valid", {15'd0, out0_valid}, 16'd0);
      chk("post_rst_out1_valid", {15'd0, out1_valid}, 16'd0);
    end
    @(posedge clk);
    #1;

`ifdef DEMUX_COUNT_EN
    // 6: delivery counters, including wrap at 16'hFFFF
    chk("cnt0_after_rst", out0_count, 16'd0);
    chk("cnt1_after_rst", out1_count, 16'd0);
    for (int i = 0; i < 3; i++) push(16'hE000 + 16'(i), 1'b1);
    cycles(2);
    chk("cnt1_three", out1_count, 16'd3);
    chk("cnt0_zero", out0_count, 16'd0);
    for (int i = 3; i < 65535; i++) push(16'(i), 1'b1);
    cycles(2);
    chk("cnt1_ffff", out1_count, 16'hFFFF);
    push(16'hF00F, 1'b1);
    cycles(2);
    chk("cnt1_wrap", out1_count, 16'h0000);
    chk("cnt0_still_zero", out0_count, 16'd0);
`endif

    // Normal operation after reset
    push(16'h5A5A, 1'b1);
    push(16'hA5A5, 1'b0);
    for (int i = 0; i < 20 && (q0.size() != 0 || q1.size() != 0); i++) cycles(1);
    chk("q0_empty_at_end", 16'(q0.size()), 16'd0);
    chk("q1_empty_at_end", 16'(q1.size()), 16'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
